// File: rtl/latrsnq_drive_seq.sv
// Sequencer that turns write/clear/preset commands into timed E/D/RN/SETN
// waveforms for a bank of set/reset D-latches. All latch pins are flop outputs.
module latrsnq_drive_seq #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int RECOV_CYC = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [WIDTH-1:0] REQ_DATA,
    output logic [WIDTH-1:0] LAT_D,
    output logic             LAT_E,
    output logic             LAT_RN,
    output logic             LAT_SETN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HR  = (HOLD_CYC > RECOV_CYC) ? HOLD_CYC : RECOV_CYC;
    localparam int MAX_CYC = (MAX_SP > MAX_HR) ? MAX_SP : MAX_HR;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_ASYNC,
        S_RECOV,
        S_ERRST
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_use_set, w_use_set_next;
    logic          w_cnt_zero;
    logic          w_done_next;
    logic          w_err_next;
    logic          w_load_d;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_load_d   = (r_state == S_IDLE) && REQ_VALID && (REQ_OP == 2'b00);

    always_comb begin
        w_next         = r_state;
        w_cnt_next     = r_cnt;
        w_use_set_next = r_use_set;
        case (r_state)
            S_IDLE: begin
                if (REQ_VALID) begin
                    case (REQ_OP)
                        2'b00: begin
                            w_next     = S_SETUP;
                            w_cnt_next = CW'(SETUP_CYC - 1);
                        end
                        2'b01: begin
                            w_next         = S_ASYNC;
                            w_cnt_next     = CW'(PULSE_CYC - 1);
                            w_use_set_next = 1'b0;
                        end
                        2'b10: begin
                            w_next         = S_ASYNC;
                            w_cnt_next     = CW'(PULSE_CYC - 1);
                            w_use_set_next = 1'b1;
                        end
                        default: w_next = S_ERRST;
                    endcase
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_next     = S_PULSE;
                    w_cnt_next = CW'(PULSE_CYC - 1);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (w_cnt_zero) begin
                    w_next     = S_HOLD;
                    w_cnt_next = CW'(HOLD_CYC - 1);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) w_next = S_IDLE;
                else            w_cnt_next = r_cnt - 1'b1;
            end
            S_ASYNC: begin
                if (w_cnt_zero) begin
                    w_next     = S_RECOV;
                    w_cnt_next = CW'(RECOV_CYC - 1);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_RECOV: begin
                if (w_cnt_zero) w_next = S_IDLE;
                else            w_cnt_next = r_cnt - 1'b1;
            end
            S_ERRST: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_done_next = (r_state != S_IDLE) && (w_next == S_IDLE);
    assign w_err_next  = (r_state == S_ERRST);

    // Pin values are registered from the next state so they switch on the
    // same edge as the state they belong to.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_use_set <= 1'b0;
            LAT_D     <= '0;
            LAT_E     <= 1'b0;
            LAT_RN    <= 1'b1;
            LAT_SETN  <= 1'b1;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_use_set <= w_use_set_next;
            if (w_load_d) LAT_D <= REQ_DATA;
            LAT_E     <= (w_next == S_PULSE);
            LAT_RN    <= !((w_next == S_ASYNC) && !w_use_set_next);
            LAT_SETN  <= !((w_next == S_ASYNC) && w_use_set_next);
            DONE      <= w_done_next;
            ERR       <= w_err_next;
        end
    end

    assign REQ_READY = (r_state == S_IDLE);
    assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_latrsnq_drive_seq.sv
// Drives two latrsnq_drive_seq instances (default and stretched timing) with
// shared directed + random commands; per-instance scoreboards check waveforms.
module tb_latrsnq_drive_seq;

    logic       CLK;
    logic       RST;
    logic       REQ_VALID;
    logic [1:0] REQ_OP;
    logic [7:0] REQ_DATA;

    logic       ready [2];
    logic [7:0] lat_d [2];
    logic       lat_e [2];
    logic       lat_rn [2];
    logic       lat_sn [2];
    logic       busy [2];
    logic       done [2];
    logic       err [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int         op;
        logic [7:0] d;
        int         t0;
        int         done_at;
    } txn_t;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int S = (k == 0) ? 1 : 3;
        localparam int P = (k == 0) ? 2 : 4;
        localparam int H = (k == 0) ? 1 : 2;
        localparam int R = (k == 0) ? 1 : 5;

        latrsnq_drive_seq #(
            .WIDTH(8), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .RECOV_CYC(R)
        ) u_dut (
            .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(ready[k]),
            .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA), .LAT_D(lat_d[k]), .LAT_E(lat_e[k]),
            .LAT_RN(lat_rn[k]), .LAT_SETN(lat_sn[k]), .BUSY(busy[k]), .DONE(done[k]),
            .ERR(err[k])
        );

        txn_t       q[$];
        txn_t       t;
        logic [7:0] mdl_d;
        int         pe, prn, psn, first;
        logic       exp_busy;

        always @(negedge CLK) begin
            if (RST) begin
                q.delete();
                mdl_d = '0;
                pe = 0; prn = 0; psn = 0; first = -1;
            end else begin
                if (q.size() > 0) exp_busy = (cyc < q[0].done_at);
                else              exp_busy = 1'b0;
                chk("busy", k, busy[k], exp_busy);
                chk("ready", k, ready[k], !exp_busy);
                chk("lat_d", k, lat_d[k], mdl_d);
                chk("rn_setn_exclusive", k, lat_rn[k] | lat_sn[k], 1);
                chk("e_during_async", k, lat_e[k] & !(lat_rn[k] & lat_sn[k]), 0);
                if (lat_e[k]) pe++;
                if (!lat_rn[k]) prn++;
                if (!lat_sn[k]) psn++;
                if ((lat_e[k] || !lat_rn[k] || !lat_sn[k]) && first < 0) first = cyc;
                if (done[k]) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", k, done[k], 0);
                    end else begin
                        t = q.pop_front();
                        chk("done_cycle", k, cyc, t.done_at);
                        chk("err", k, err[k], (t.op == 3) ? 1 : 0);
                        chk("e_cycles", k, pe, (t.op == 0) ? P : 0);
                        chk("rn_cycles", k, prn, (t.op == 1) ? P : 0);
                        chk("setn_cycles", k, psn, (t.op == 2) ? P : 0);
                        chk("pin_start", k, first,
                            (t.op == 0) ? t.t0 + S : (t.op == 3) ? -1 : t.t0);
                    end
                    pe = 0; prn = 0; psn = 0; first = -1;
                end else begin
                    chk("err_no_done", k, err[k], 0);
                    if (q.size() > 0 && cyc >= q[0].done_at) begin
                        chk("done_timeout", k, done[k], 1);
                        void'(q.pop_front());
                        pe = 0; prn = 0; psn = 0; first = -1;
                    end
                end
                if (REQ_VALID && ready[k]) begin
                    t.op = int'(REQ_OP);
                    t.d  = REQ_DATA;
                    t.t0 = cyc + 1;
                    case (t.op)
                        0:       t.done_at = t.t0 + S + P + H;
                        1, 2:    t.done_at = t.t0 + P + R;
                        default: t.done_at = t.t0 + 1;
                    endcase
                    if (t.op == 0) mdl_d = REQ_DATA;
                    q.push_back(t);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (ready[0] && ready[1]) break;
            tick();
        end
        chk("idle_reached", 0, ready[0] & ready[1], 1);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_DATA  = d;
        tick();
        REQ_VALID = 1'b0;
    endtask

    task automatic check_reset_pins();
        for (int k = 0; k < 2; k++) begin
            chk("rst_lat_e", k, lat_e[k], 0);
            chk("rst_lat_rn", k, lat_rn[k], 1);
            chk("rst_lat_setn", k, lat_sn[k], 1);
            chk("rst_ready", k, ready[k], 1);
            chk("rst_done", k, done[k], 0);
            chk("rst_err", k, err[k], 0);
        end
    endtask

    initial begin
        RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = 2'b00; REQ_DATA = '0;
        repeat (3) tick();
        check_reset_pins();
        for (int k = 0; k < 2; k++) begin
            chk("rst_lat_d", k, lat_d[k], 0);
            chk("rst_busy", k, busy[k], 0);
        end
        RST = 1'b0;
        tick();

        send(2'b00, 8'hA5);
        wait_idle();
        send(2'b11, 8'h00);
        wait_idle();

        // Clear then preset with VALID held: preset lands on inst0's DONE cycle.
        REQ_VALID = 1'b1; REQ_OP = 2'b01; REQ_DATA = 8'h11;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (done[0]) break;
            tick();
        end
        chk("clear_done_seen", 0, done[0], 1);
        REQ_OP = 2'b10;
        tick();
        REQ_VALID = 1'b0;
        wait_idle();

        send(2'b00, 8'h3C);
        REQ_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            REQ_OP   = 2'($urandom_range(0, 3));
            REQ_DATA = 8'($urandom_range(0, 255));
            if (ready[0]) REQ_VALID = 1'b0;
            tick();
        end
        REQ_VALID = 1'b0;
        wait_idle();

        send(2'b00, 8'h5A);
        for (int i = 0; i < 20; i++) begin
            if (lat_e[0]) break;
            tick();
        end
        chk("reach_e_high", 0, lat_e[0], 1);
        #2 RST = 1'b1;
        #1 check_reset_pins();
        tick();
        RST = 1'b0;
        tick();
        send(2'b00, 8'hC3);
        wait_idle();

        send(2'b01, 8'h00);
        chk("reach_rn_low", 0, lat_rn[0], 0);
        #2 RST = 1'b1;
        #1 check_reset_pins();
        tick();
        RST = 1'b0;
        tick();
        send(2'b00, 8'h96);
        wait_idle();

        for (int i = 0; i < 600; i++) begin
            REQ_VALID = ($urandom_range(0, 2) != 0);
            REQ_OP    = 2'($urandom_range(0, 3));
            REQ_DATA  = 8'($urandom_range(0, 255));
            tick();
        end
        REQ_VALID = 1'b0;
        wait_idle();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
